// File: rtl/int8_arith_pkg.sv
// Shared signed int8 arithmetic definitions: saturation limits, divider FSM states
// and a generic signed clamp used by both the multiplier and the divider.
package int8_arith_pkg;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [31:0] val;
  } sat_t;

  // Clamp a wide signed value into the signed range of a w-bit result.
  function automatic sat_t sat_clamp(input logic signed [31:0] v, input int w);
    sat_t               r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end else begin
      r.ovf = 1'b0;
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/int8_udiv_step.sv
// One restoring division step on unsigned magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits, and emit the resulting quotient bit.
module int8_udiv_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] rem_i,
  input  logic [WIDTH:0] dmag_i,
  input  logic           bit_i,
  output logic [WIDTH:0] rem_o,
  output logic           q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dext;

  assign shifted = {rem_i, bit_i};
  assign dext    = {1'b0, dmag_i};
  assign q_o     = (shifted >= dext);
  // The restored remainder is always below the divisor, so the top bit drops safely.
  assign rem_o   = (WIDTH + 1)'(q_o ? shifted - dext : shifted);

endmodule

// File: rtl/int8_div_seq.sv
// Sequential signed saturating divider: one restoring step per clock over operand
// magnitudes, then sign fix-up, clamp and divide-by-zero override into output registers.
module int8_div_seq
  import int8_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             saturated
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic signed [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state_q;
  logic [CW-1:0]           count_q;
  logic [WIDTH-1:0]        a_sh_q;
  logic [WIDTH:0]          b_mag_q;
  logic                    sign_a_q;
  logic                    sign_b_q;
  logic                    b_zero_q;
  logic signed [WIDTH-1:0] dividend_q;
  logic [WIDTH:0]          rem_q;
  logic [WIDTH-1:0]        quo_q;

  logic                    out_valid_q;
  logic signed [WIDTH-1:0] quotient_q;
  logic signed [WIDTH-1:0] remainder_q;
  logic                    dbz_q;
  logic                    sat_q;

  logic [WIDTH:0]          rem_d;
  logic                    qbit_d;
  logic signed [WIDTH+1:0] q_wide;
  logic signed [WIDTH+1:0] r_wide;
  sat_t                    q_sat;

  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  int8_udiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .dmag_i (b_mag_q),
    .bit_i  (a_sh_q[WIDTH-1]),
    .rem_o  (rem_d),
    .q_o    (qbit_d)
  );

  always_comb begin
    q_wide = signed'({2'b00, quo_q});
    if (sign_a_q ^ sign_b_q) q_wide = -q_wide;
    r_wide = signed'({1'b0, rem_q});
    if (sign_a_q) r_wide = -r_wide;
    q_sat = sat_clamp(32'(q_wide), WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= WIDTH'(mag(dividend));
            b_mag_q    <= mag(divisor);
            sign_a_q   <= dividend[WIDTH-1];
            sign_b_q   <= divisor[WIDTH-1];
            b_zero_q   <= (divisor == '0);
            dividend_q <= dividend;
            rem_q      <= '0;
            quo_q      <= '0;
            count_q    <= CW'(WIDTH);
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (count_q != '0) begin
            rem_q   <= rem_d;
            quo_q   <= {quo_q[WIDTH-2:0], qbit_d};
            a_sh_q  <= a_sh_q << 1;
            count_q <= count_q - CW'(1);
          end else begin
            // Divide-by-zero shares the full latency; only the result is replaced.
            if (b_zero_q) begin
              quotient_q  <= sign_a_q ? QMIN : QMAX;
              remainder_q <= dividend_q;
              dbz_q       <= 1'b1;
              sat_q       <= 1'b0;
            end else begin
              quotient_q  <= WIDTH'(q_sat.val);
              remainder_q <= WIDTH'(r_wide);
              dbz_q       <= 1'b0;
              sat_q       <= q_sat.ovf;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign saturated   = sat_q;

endmodule

// File: tb/tb_int8_div_seq.sv
// Self-checking bench for int8_div_seq: vector table plus randomized cases through a
// scoreboard, with backpressure, ignored-input and mid-operation reset sequences.
module tb_int8_div_seq;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [7:0] q;
    logic signed [7:0] r;
    logic              dz;
    logic              sat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] dividend;
  logic signed [7:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] quotient;
  logic signed [7:0] remainder;
  logic              div_by_zero;
  logic              saturated;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tbl[12];

  int8_div_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input bit dz, input bit sat);
    vec_t v;
    v.a = 8'(a); v.b = 8'(b); v.q = 8'(q); v.r = 8'(r); v.dz = dz; v.sat = sat;
    return v;
  endfunction

  // Independent reference built on the simulator's signed integer division.
  function automatic vec_t model(input logic signed [7:0] a, input logic signed [7:0] b);
    int ai, bi, qi, ri;
    ai = a; bi = b;
    if (bi == 0) return mk(ai, bi, (ai >= 0) ? 127 : -128, ai, 1'b1, 1'b0);
    qi = ai / bi;
    ri = ai % bi;
    if (qi > 127) return mk(ai, bi, 127, 0, 1'b0, 1'b1);
    return mk(ai, bi, qi, ri, 1'b0, 1'b0);
  endfunction

  task automatic run_op(input vec_t e, input int hold, input bit junk);
    int                cyc;
    bit                got;
    vec_t              x;
    logic signed [7:0] hq, hr;
    logic              hd, hs;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    check("in_ready_idle", int'(in_ready), 1);
    dividend  = e.a;
    divisor   = e.b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    sb.push_back(e);
    in_valid = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (junk && cyc == 3) begin
        in_valid = 1'b1; dividend = 8'sd77; divisor = 8'sd3;
      end
      tick();
      cyc++;
      if (junk) check("in_ready_busy", int'(in_ready), 0);
      got = out_valid;
    end
    in_valid = 1'b0;
    check("latency", cyc, 9);
    if (got && sb.size() > 0) begin
      x = sb.pop_front();
      check("quotient", int'(quotient), int'(x.q));
      check("remainder", int'(remainder), int'(x.r));
      check("div_by_zero", int'(div_by_zero), int'(x.dz));
      check("saturated", int'(saturated), int'(x.sat));
    end
    if (!got) sb.delete();
    hq = quotient; hr = remainder; hd = div_by_zero; hs = saturated;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = -8'sd99; divisor = 8'sd2;
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_q", int'(quotient), int'(hq));
      check("hold_r", int'(remainder), int'(hr));
      check("hold_flags", int'({div_by_zero, saturated}), int'({hd, hs}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    tick(); tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_flags", int'({div_by_zero, saturated}), 0);
    rst = 1'b0;
    tick();

    tbl[0]  = mk( 100,    7,   14,  2, 1'b0, 1'b0);
    tbl[1]  = mk(-100,    7,  -14, -2, 1'b0, 1'b0);
    tbl[2]  = mk( 100,   -7,  -14,  2, 1'b0, 1'b0);
    tbl[3]  = mk(-100,   -7,   14, -2, 1'b0, 1'b0);
    tbl[4]  = mk(   0,   -5,    0,  0, 1'b0, 1'b0);
    tbl[5]  = mk(-128,   -1,  127,  0, 1'b0, 1'b1);
    tbl[6]  = mk(-128,    1, -128,  0, 1'b0, 1'b0);
    tbl[7]  = mk( 127,   -1, -127,  0, 1'b0, 1'b0);
    tbl[8]  = mk(-128, -128,    1,  0, 1'b0, 1'b0);
    tbl[9]  = mk(   5,    0,  127,  5, 1'b1, 1'b0);
    tbl[10] = mk(  -5,    0, -128, -5, 1'b1, 1'b0);
    tbl[11] = mk(   0,    0,  127,  0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) run_op(tbl[i], 0, 1'b0);

    // Backpressure with junk operands offered during CALC and DONE.
    run_op(mk(100, 7, 14, 2, 1'b0, 1'b0), 5, 1'b1);
    run_op(mk(-128, -1, 127, 0, 1'b0, 1'b1), 3, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic signed [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(model(ra, rb), i % 3, 1'b0);
    end

    // Reset three cycles into a division must discard it entirely.
    dividend = 8'sd90; divisor = 8'sd9; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_q", int'(quotient), 0);
    check("midrst_r", int'(remainder), 0);
    check("midrst_flags", int'({div_by_zero, saturated}), 0);
    rst = 1'b0;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 14; i++) begin
        tick();
        if (out_valid) stale++;
      end
      check("no_stale_result", stale, 0);
    end
    run_op(mk(90, 9, 10, 0, 1'b0, 1'b0), 0, 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
